// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline register slice.
// Holds the control-bundle width, the reset PC and the named bit positions
// inside the packed decoder control bundle. An all-zero bundle is a NOP
// because it asserts neither regwrite nor memwrite.
package pipe_pkg;

    localparam int          DATA_W   = 32;
    localparam int          CTRL_W   = 12;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Bit positions in the control bundle
    localparam int REGWRITE    = 0;
    localparam int MEMTOREG    = 1;
    localparam int MEMWRITE    = 2;
    localparam int BRANCH      = 3;
    localparam int ALUSRC      = 4;
    localparam int REGDST      = 5;
    localparam int ALUCTRL_LSB = 6;   // ALUCTRL occupies [8:6]
    localparam int ALUCTRL_W   = 3;
    localparam int SPARE_LSB   = 9;   // [11:9] reserved

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stage_regs_reg.sv
// pipe_reg: generic width register used for the PC and each inter-stage
// register.
//   clk  rising-edge clock
//   rst  synchronous active-high reset, loads RST_VAL
//   en   load enable
//   clr  synchronous clear to zero; wins over a low enable
//   d/q  data in / registered data out
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)      q <= RST_VAL;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC register and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline
// registers of a 5-stage MIPS pipeline, with per-stage valid bits and a
// retired-instruction counter.
//   clk, rst                     clock, synchronous active-high reset
//   stallF/stallD/flushD/flushE  hazard-unit controls
//   pcnextF -> pcF               PC register
//   instrF, pcplus4F -> *D       IF/ID
//   ctrlD, srca/srcb/signimmD, rs/rt/rdD -> *E   ID/EX
//   aluoutE, writedataE, writeregE, ctrlE -> *M  EX/MEM
//   readdataM, aluoutM, writeregM, ctrlM -> *W   MEM/WB
//   validD..validW               stage holds a real instruction
//   instret                      count of instructions leaving W
module pipe_stage_regs #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = pipe_pkg::CTRL_W,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(pipe_pkg::RESET_PC),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic [DATA_W-1:0] pcnextF,
    output logic [DATA_W-1:0] pcF,
    input  logic [DATA_W-1:0] instrF,
    input  logic [DATA_W-1:0] pcplus4F,
    output logic [DATA_W-1:0] instrD,
    output logic [DATA_W-1:0] pcplus4D,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [DATA_W-1:0] srcaD,
    input  logic [DATA_W-1:0] srcbD,
    input  logic [DATA_W-1:0] signimmD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [DATA_W-1:0] srcaE,
    output logic [DATA_W-1:0] srcbE,
    output logic [DATA_W-1:0] signimmE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    input  logic [DATA_W-1:0] aluoutE,
    input  logic [DATA_W-1:0] writedataE,
    input  logic [4:0]        writeregE,
    output logic [CTRL_W-1:0] ctrlM,
    output logic [DATA_W-1:0] aluoutM,
    output logic [DATA_W-1:0] writedataM,
    output logic [4:0]        writeregM,
    input  logic [DATA_W-1:0] readdataM,
    output logic [CTRL_W-1:0] ctrlW,
    output logic [DATA_W-1:0] aluoutW,
    output logic [DATA_W-1:0] readdataW,
    output logic [4:0]        writeregW,
    output logic              validD,
    output logic              validE,
    output logic              validM,
    output logic              validW,
    output logic [CNT_W-1:0]  instret
);
    import pipe_pkg::*;

    localparam int FD_W = 1 + 2 * DATA_W;
    localparam int DE_W = 1 + CTRL_W + 3 * DATA_W + 15;
    localparam int EM_W = 1 + CTRL_W + 2 * DATA_W + 5;
    localparam int MW_W = 1 + CTRL_W + 2 * DATA_W + 5;

    logic [FD_W-1:0] fd_q;
    logic [DE_W-1:0] de_q;
    logic [EM_W-1:0] em_q;
    logic [MW_W-1:0] mw_q;

    // PC: only a stall holds it
    pipe_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(~stallF), .clr(1'b0),
        .d(pcnextF), .q(pcF)
    );

    // IF/ID: a stall masks the flush, since the branch is re-resolved
    // once the stall lifts. Valid is stored alongside the payload.
    pipe_reg #(.W(FD_W)) u_fd (
        .clk(clk), .rst(rst), .en(~stallD), .clr(flushD & ~stallD),
        .d({1'b1, instrF, pcplus4F}), .q(fd_q)
    );
    assign {validD, instrD, pcplus4D} = fd_q;

    // ID/EX: no enable; flush inserts a bubble with a NOP control bundle
    pipe_reg #(.W(DE_W)) u_de (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flushE),
        .d({validD, ctrlD, srcaD, srcbD, signimmD, rsD, rtD, rdD}),
        .q(de_q)
    );
    assign {validE, ctrlE, srcaE, srcbE, signimmE, rsE, rtE, rdE} = de_q;

    // EX/MEM and MEM/WB always advance
    pipe_reg #(.W(EM_W)) u_em (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
        .d({validE, ctrlE, aluoutE, writedataE, writeregE}),
        .q(em_q)
    );
    assign {validM, ctrlM, aluoutM, writedataM, writeregM} = em_q;

    pipe_reg #(.W(MW_W)) u_mw (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
        .d({validM, ctrlM, aluoutM, readdataM, writeregM}),
        .q(mw_q)
    );
    assign {validW, ctrlW, aluoutW, readdataW, writeregW} = mw_q;

    // An instruction retires on the edge that moves it out of W;
    // the counter wraps freely.
    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (validW) instret <= instret + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;   // small counter so wrap is reachable

    logic              clk = 1'b0;
    logic              rst;
    logic              stallF, stallD, flushD, flushE;
    logic [DATA_W-1:0] pcnextF, pcF, instrF, pcplus4F, instrD, pcplus4D;
    logic [CTRL_W-1:0] ctrlD, ctrlE, ctrlM, ctrlW;
    logic [DATA_W-1:0] srcaD, srcbD, signimmD, srcaE, srcbE, signimmE;
    logic [4:0]        rsD, rtD, rdD, rsE, rtE, rdE;
    logic [DATA_W-1:0] aluoutE, writedataE, aluoutM, writedataM, readdataM;
    logic [DATA_W-1:0] aluoutW, readdataW;
    logic [4:0]        writeregE, writeregM, writeregW;
    logic              validD, validE, validM, validW;
    logic [CNT_W-1:0]  instret;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Stage-logic stand-ins driven from the pipeline registers
    assign ctrlD      = instrD[CTRL_W-1:0] ^ 12'hA5A;
    assign srcaD      = instrD;
    assign srcbD      = {16'h0, instrD[15:0]};
    assign signimmD   = {{16{instrD[15]}}, instrD[15:0]};
    assign rsD        = instrD[25:21];
    assign rtD        = instrD[20:16];
    assign rdD        = instrD[15:11];
    assign aluoutE    = srcaE + srcbE;
    assign writedataE = srcbE;
    assign writeregE  = rtE;
    assign readdataM  = aluoutM ^ 32'hFFFF_0000;

    pipe_stage_regs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W),
                      .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .pcnextF(pcnextF), .pcF(pcF),
        .instrF(instrF), .pcplus4F(pcplus4F), .instrD(instrD),
        .pcplus4D(pcplus4D), .ctrlD(ctrlD), .srcaD(srcaD), .srcbD(srcbD),
        .signimmD(signimmD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .ctrlE(ctrlE), .srcaE(srcaE), .srcbE(srcbE), .signimmE(signimmE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .aluoutE(aluoutE),
        .writedataE(writedataE), .writeregE(writeregE), .ctrlM(ctrlM),
        .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
        .readdataM(readdataM), .ctrlW(ctrlW), .aluoutW(aluoutW),
        .readdataW(readdataW), .writeregW(writeregW), .validD(validD),
        .validE(validE), .validM(validM), .validW(validW), .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then return 1 time unit after the edge
    task automatic step(input logic r, input logic [31:0] instr, input logic [31:0] pcn,
                        input logic sf, input logic sd, input logic fd, input logic fe);
        rst = r; instrF = instr; pcplus4F = pcn; pcnextF = pcn;
        stallF = sf; stallD = sd; flushD = fd; flushE = fe;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T0: reset with every stall/flush asserted
        step(1'b1, 32'hFFFF_FFFF, 32'hDEAD_0000, 1, 1, 1, 1);
        chk("rst_pcF",     pcF,           32'h0);
        chk("rst_instrD",  instrD,        32'h0);
        chk("rst_ctrlE",   32'(ctrlE),    32'h0);
        chk("rst_validD",  32'(validD),   32'h0);
        chk("rst_validE",  32'(validE),   32'h0);
        chk("rst_validM",  32'(validM),   32'h0);
        chk("rst_validW",  32'(validW),   32'h0);
        chk("rst_instret", 32'(instret),  32'h0);

        // T1..T5: first instruction flows through
        step(1'b0, 32'h2008_0005, 32'd4, 0, 0, 0, 0);
        chk("t1_instrD",   instrD,        32'h2008_0005);
        chk("t1_pcplus4D", pcplus4D,      32'd4);
        chk("t1_validD",   32'(validD),   32'h1);
        chk("t1_pcF",      pcF,           32'd4);
        step(1'b0, 32'h2009_0007, 32'd8, 0, 0, 0, 0);
        chk("t2_ctrlE",    32'(ctrlE),    32'hA5F);
        chk("t2_validE",   32'(validE),   32'h1);
        step(1'b0, 32'h200A_0009, 32'd12, 0, 0, 0, 0);
        chk("t3_ctrlM",    32'(ctrlM),    32'hA5F);
        chk("t3_validM",   32'(validM),   32'h1);
        step(1'b0, 32'h200B_000B, 32'd16, 0, 0, 0, 0);
        chk("t4_ctrlW",    32'(ctrlW),    32'hA5F);
        chk("t4_validW",   32'(validW),   32'h1);
        chk("t4_aluoutW",  aluoutW,       32'h2008_000A);
        chk("t4_readW",    readdataW,     32'hDFF7_000A);
        chk("t4_wregW",    32'(writeregW), 32'd8);
        chk("t4_instret",  32'(instret),  32'd0);
        step(1'b0, 32'h200C_000D, 32'd20, 0, 0, 0, 0);
        chk("t5_instret",  32'(instret),  32'd1);

        // T6,T7: two-cycle stall with bubble into E, PC mux changing
        step(1'b0, 32'hBAD0_0001, 32'h100, 1, 1, 0, 1);
        chk("t6_pcF",      pcF,           32'd20);
        chk("t6_instrD",   instrD,        32'h200C_000D);
        chk("t6_validE",   32'(validE),   32'h0);
        chk("t6_instret",  32'(instret),  32'd2);
        step(1'b0, 32'hBAD0_0002, 32'h200, 1, 1, 0, 1);
        chk("t7_pcF",      pcF,           32'd20);
        chk("t7_instrD",   instrD,        32'h200C_000D);
        chk("t7_validD",   32'(validD),   32'h1);
        step(1'b0, 32'h200D_000F, 32'd24, 0, 0, 0, 0);
        chk("t8_instrD",   instrD,        32'h200D_000F);
        chk("t8_validE",   32'(validE),   32'h1);
        chk("t8_pcF",      pcF,           32'd24);
        chk("t8_instret",  32'(instret),  32'd4);

        // T9: lw-use stall, one cycle
        step(1'b0, 32'hBAD0_0003, 32'h300, 1, 1, 0, 1);
        chk("t9_ctrlE",    32'(ctrlE),    32'h0);
        chk("t9_srcaE",    srcaE,         32'h0);
        chk("t9_validE",   32'(validE),   32'h0);
        chk("t9_instrD",   instrD,        32'h200D_000F);
        chk("t9_pcF",      pcF,           32'd24);
        chk("t9_instret",  32'(instret),  32'd4);
        step(1'b0, 32'h200E_0011, 32'd28, 0, 0, 0, 0);
        chk("t10_validM",  32'(validM),   32'h0);
        chk("t10_validW",  32'(validW),   32'h1);
        chk("t10_instret", 32'(instret),  32'd4);
        step(1'b0, 32'h200F_0013, 32'd32, 0, 0, 0, 0);
        chk("t11_validW",  32'(validW),   32'h0);
        chk("t11_instret", 32'(instret),  32'd5);

        // T12: branch flush of D
        step(1'b0, 32'h2010_0015, 32'd36, 0, 0, 1, 0);
        chk("t12_instrD",  instrD,        32'h0);
        chk("t12_pc4D",    pcplus4D,      32'h0);
        chk("t12_validD",  32'(validD),   32'h0);
        chk("t12_instret", 32'(instret),  32'd5);

        // T13,T14: flush while stalled is dropped
        step(1'b0, 32'h2011_0017, 32'd40, 0, 0, 0, 0);
        chk("t13_instrD",  instrD,        32'h2011_0017);
        step(1'b0, 32'hBAD0_0004, 32'h400, 1, 1, 1, 1);
        chk("t14_instrD",  instrD,        32'h2011_0017);
        chk("t14_validD",  32'(validD),   32'h1);
        chk("t14_pcF",     pcF,           32'd40);
        chk("t14_instret", 32'(instret),  32'd7);

        // T15..T18: fill all four stages
        step(1'b0, 32'h2012_0019, 32'd44, 0, 0, 0, 0);
        step(1'b0, 32'h2013_001B, 32'd48, 0, 0, 0, 0);
        step(1'b0, 32'h2014_001D, 32'd52, 0, 0, 0, 0);
        step(1'b0, 32'h2015_001F, 32'd56, 0, 0, 0, 0);
        chk("t18_valids",  32'({validD, validE, validM, validW}), 32'hF);
        chk("t18_instret", 32'(instret),  32'd9);

        // T19: reset mid-flight, hazard controls asserted alongside
        step(1'b1, 32'h2016_0021, 32'd60, 1, 1, 1, 1);
        chk("t19_valids",  32'({validD, validE, validM, validW}), 32'h0);
        chk("t19_instret", 32'(instret),  32'd0);
        chk("t19_pcF",     pcF,           32'h0);
        chk("t19_instrD",  instrD,        32'h0);

        // Continuous retirement: instret = k-4 after step k, wrapping at 16
        for (int k = 1; k <= 21; k++) begin
            step(1'b0, 32'h3000_0000 + 32'(k), 32'(4 * k), 0, 0, 0, 0);
            if (k == 19) chk("wrap_k19", 32'(instret), 32'd15);
            if (k == 20) chk("wrap_k20", 32'(instret), 32'd0);
            if (k == 21) chk("wrap_k21", 32'(instret), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Consumer end of the hazard-control interface: the PC register plus the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage MIPS pipeline.
- Applies stallF/stallD/flushD/flushE exactly as the hazard unit intends.
- Tracks a per-stage valid bit and counts retired instructions for bring-up and perf checks.
- Instantiated once in the datapath, between the stage logic blocks.

Parameters:
- DATA_W, 32, width of PC, instruction and data words.
- CTRL_W, 12, width of the packed decoder control bundle.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stallF  in  1  hold PC.
- stallD  in  1  hold IF/ID.
- flushD  in  1  clear IF/ID; branch taken (pcsrcD).
- flushE  in  1  clear ID/EX; insert bubble.
- pcnextF  in  DATA_W  next PC from the PC mux.
- pcF  out  DATA_W  current fetch PC.
- instrF, pcplus4F  in  DATA_W  fetch results.
- instrD, pcplus4D  out  DATA_W  decode-stage copies.
- ctrlD  in  CTRL_W  decoder control bundle.
- srcaD, srcbD, signimmD  in  DATA_W  decode operands.
- rsD, rtD, rdD  in  5  register specifiers.
- ctrlE  out  CTRL_W; srcaE, srcbE, signimmE  out  DATA_W; rsE, rtE, rdE  out  5.
- aluoutE, writedataE  in  DATA_W; writeregE  in  5.
- ctrlM  out  CTRL_W; aluoutM, writedataM  out  DATA_W; writeregM  out  5.
- readdataM  in  DATA_W.
- ctrlW  out  CTRL_W; aluoutW, readdataW  out  DATA_W; writeregW  out  5.
- validD, validE, validM, validW  out  1  stage holds a real instruction.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=1 at clk edge): pcF=RESET_PC. Every other register and output is 0, including all valid bits and instret. Reset overrides stall and flush.
- PC: if stallF, pcF holds; otherwise pcF <= pcnextF.
- IF/ID, priority stallD > flushD > load:
  - stallD: instrD, pcplus4D and validD hold.
  - else flushD: all fields cleared to 0, validD=0.
  - else: load instrF/pcplus4F, validD=1.
  - stallD together with flushD is a hold; the flush is dropped, because the branch is re-resolved after the stall.
- ID/EX: no enable.
  - flushE: every field cleared to 0, validE=0. ctrl all-zero is a NOP: no regwrite, no memwrite.
  - else: latch all D inputs, and validE<=validD.
  - flushE and stallD in the same cycle is the normal lw/branch stall: D holds, E gets a bubble.
- EX/MEM and MEM/WB: always advance. No stall or flush inputs.
  - ctrlM<=ctrlE, ctrlW<=ctrlM.
  - Valid bits propagate: validM<=validE, validW<=validM.
- instret: +1 on each clk edge where validW=1. Wraps modulo 2^CNT_W with no saturation.
- Latency:
  - An instruction presented at F appears at D 1 cycle later, at E 2, at M 3, at W 4 (absent stalls).
  - instret increments on the edge after W is reached.
- Valid bits are derived only from stall/flush history. ctrl bits never affect valid.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W, RESET_PC.
  - Named bit positions in the ctrl bundle: REGWRITE, MEMTOREG, MEMWRITE, BRANCH, ALUSRC, REGDST, ALUCTRL[2:0], spares.
  - NOP_CTRL = all-zero bundle.
- One natural sub-module, pipe_reg: a parameterised-width register with synchronous rst, enable and synchronous clear, clear taking priority over a low enable. Instantiated once per stage.

Test Plan:
- Reset then release with no stalls, instrF=32'h2008_0005 at cycle 1:
  - instrD=32'h2008_0005 at cycle 2; ctrlE/ctrlM/ctrlW follow at cycles 3/4/5.
  - validW=1 at cycle 5; instret=1 after cycle 5.
- stallF=stallD=1 for 2 cycles with pcnextF changing:
  - pcF and instrD are unchanged across both cycles.
  - Pipe resumes with no instruction lost or duplicated (instret counts each once).
- lw stall: stallF=stallD=flushE=1 for one cycle:
  - ctrlE=0 and validE=0 next cycle; D holds.
  - Downstream: validM=0, then validW=0; instret skips exactly one slot.
- flushD=1 with stallD=0: instrD=0, validD=0.
- flushD=1 with stallD=1: instrD holds its previous value and validD stays 1.
- Assert rst while 4 valid instructions are in flight:
  - Next cycle all valids=0, instret=0, pcF=RESET_PC.
  - stall/flush asserted simultaneously with rst have no effect.
- instret preloaded near all-ones via force, then retire 2: count wraps to 1.
